// File: rtl/spectol_writer.sv
// spectol_writer: renders one spectrum column into the frame buffer, bottom row first.
// It sits at the far end of the StartSW/BusySW/EndSW handshake.
// Optional per-column peak-hold marker is enabled by defining SPECTOL_PEAK_HOLD_EN.
module spectol_writer #(
    parameter int HEIGHT   = 240,
    parameter int bw_level = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                StartSW,
    input  logic [8:0]          X,
    input  logic [bw_level-1:0] Level,
    output logic                BusySW,
    output logic                EndSW,
    output logic                FBWriteEn,
    input  logic                FBReady,
    output logic [16:0]         FBAddr,
    output logic [1:0]          FBData
);

    // Level is held one bit wider so that a clamp to HEIGHT=256 cannot wrap.
    localparam int LW = bw_level + 1;
    // The row counter and the level are compared at a common width.
    localparam int CW = (LW > 9) ? LW : 9;
    localparam logic [8:0] HM1 = 9'(HEIGHT - 1);

`ifdef SPECTOL_PEAK_HOLD_EN
    typedef enum logic [2:0] {IDLE, PKRD, WRITE, DONE, CLEAR} state_t;
    localparam state_t RST_STATE = CLEAR;
    localparam state_t RUN_STATE = PKRD;
`else
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    localparam state_t RST_STATE = IDLE;
    localparam state_t RUN_STATE = WRITE;
`endif

    state_t          state, stateNext;
    logic [8:0]      xReg;
    logic [LW-1:0]   lc, lcNext;
    logic [8:0]      r;
    logic [7:0]      row;
    logic [1:0]      pix;
    logic            canStart;
    logic            busyRaw;

`ifdef SPECTOL_PEAK_HOLD_EN
    logic [bw_level-1:0] peakRam [512];
    logic [bw_level-1:0] q, qm1, pSat;
    logic [LW-1:0]       pReg, pNext;
    logic [8:0]          clrCnt;
`endif

    assign canStart = (state == IDLE) || (state == DONE);
    assign lcNext   = (32'(Level) > HEIGHT) ? LW'(HEIGHT) : {1'b0, Level};
    assign row      = 8'(HM1 - r);

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= RST_STATE;
        else       state <= stateNext;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        stateNext = state;
        busyRaw   = 1'b0;
        EndSW     = 1'b0;
        FBWriteEn = 1'b0;
        case (state)
            IDLE: if (StartSW) stateNext = RUN_STATE;
`ifdef SPECTOL_PEAK_HOLD_EN
            PKRD: begin
                busyRaw   = 1'b1;
                stateNext = WRITE;
            end
            CLEAR: begin
                busyRaw = 1'b1;
                if (clrCnt == 9'd511) stateNext = IDLE;
            end
`endif
            WRITE: begin
                busyRaw   = 1'b1;
                FBWriteEn = 1'b1;
                if (FBReady && r == HM1) stateNext = DONE;
            end
            DONE: begin
                EndSW     = 1'b1;
                stateNext = StartSW ? RUN_STATE : IDLE;
            end
            default: stateNext = RST_STATE;
        endcase
        // The clear sweep starts only once Reset is released; busy stays low while held.
        BusySW = busyRaw && !Reset;
    end

    // Column latch and row counter; r only moves on an accepted write.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            xReg <= '0;
            lc   <= '0;
            r    <= '0;
        end else if (StartSW && canStart) begin
            xReg <= X;
            lc   <= lcNext;
            r    <= '0;
        end else if (state == WRITE && FBReady) begin
            r <= r + 9'd1;
        end
    end

    // Pixel code for the current row.
    always_comb begin
        pix = 2'd0;
        if (CW'(r) < CW'(lc)) pix = 2'd1;
`ifdef SPECTOL_PEAK_HOLD_EN
        else if (CW'(pReg) > CW'(lc) && CW'(r) == CW'(pReg) - CW'(1)) pix = 2'd2;
`endif
    end

    assign FBAddr = (state == WRITE) ? {row, xReg} : 17'd0;
    assign FBData = (state == WRITE) ? pix : 2'd0;

`ifdef SPECTOL_PEAK_HOLD_EN
    // Decaying peak: follow the bar upward, otherwise fall one row per column.
    assign q     = peakRam[xReg];
    assign qm1   = (q == '0) ? '0 : q - bw_level'(1);
    assign pNext = (lc >= {1'b0, q}) ? lc : {1'b0, qm1};
    assign pSat  = pReg[LW-1] ? '1 : pReg[bw_level-1:0];

    // Peak value for the column in flight, and the clear-sweep address.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pReg   <= '0;
            clrCnt <= '0;
        end else begin
            if (state == PKRD)  pReg   <= pNext;
            if (state == CLEAR) clrCnt <= clrCnt + 9'd1;
        end
    end

    // Peak RAM: zeroed by the clear sweep, updated when a column completes.
    always_ff @(posedge Clock) begin
        if (state == CLEAR)     peakRam[clrCnt] <= '0;
        else if (state == DONE) peakRam[xReg]   <= pSat;
    end
`endif

endmodule

// File: tb/tb_spectol_writer.sv
// Self-checking bench for spectol_writer: directed columns plus random columns,
// each checked against a row-by-row model of the expected pixel codes.
module tb_spectol_writer;
    localparam int H  = 240;
    localparam int BW = 9;
`ifdef SPECTOL_PEAK_HOLD_EN
    localparam int PK   = 1;
    localparam bit PEAK = 1'b1;
    localparam int CLRN = 512;
`else
    localparam int PK   = 0;
    localparam bit PEAK = 1'b0;
    localparam int CLRN = 0;
`endif

    logic          Clock = 1'b0;
    logic          Reset, StartSW, FBReady;
    logic [8:0]    X;
    logic [BW-1:0] Level;
    logic          BusySW, EndSW, FBWriteEn;
    logic [16:0]   FBAddr;
    logic [1:0]    FBData;

    int nCmp = 0;
    int nBad = 0;
    int pk[512];

    spectol_writer #(.HEIGHT(H), .bw_level(BW)) dut (
        .Clock(Clock), .Reset(Reset), .StartSW(StartSW), .X(X), .Level(Level),
        .BusySW(BusySW), .EndSW(EndSW), .FBWriteEn(FBWriteEn), .FBReady(FBReady),
        .FBAddr(FBAddr), .FBData(FBData)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int expCode(input int r, input int lc, input int p);
        if (r < lc) return 1;
        if (PEAK && p > lc && r == p - 1) return 2;
        return 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge Clock); #1; end
    endtask

    // Waits out the post-reset clear sweep (none without peak hold).
    task automatic waitIdle(input string tag);
        int n = 0;
        int stray = 0;
        while (BusySW && n < 1000) begin
            StartSW = (n == 100);
            @(negedge Clock);
            if (FBWriteEn || EndSW) stray++;
            n++;
        end
        StartSW = 1'b0;
        chk({tag, "_clr_cycles"}, n, CLRN);
        chk({tag, "_clr_stray"}, stray, 0);
        repeat (3) begin
            @(negedge Clock);
            if (BusySW || FBWriteEn) stray++;
        end
        chk({tag, "_clr_start_ignored"}, stray, 0);
    endtask

    // mode: 0 = FBReady high, 1 = toggling, 2 = random.
    task automatic runCol(input int x, input int lvl, input int mode,
                          input int injectAt, input int abortAt, input string tag);
        int lc, q, p, cyc, stalls, firstW, unstable, bad, coinc, endCyc;
        bit prevStall, done;
        logic [16:0] prevA;
        logic [1:0] prevD;
        int qa[$];
        int qd[$];
        lc = (lvl > H) ? H : lvl;
        q  = pk[x];
        p  = PEAK ? ((lc >= q) ? lc : ((q == 0) ? 0 : q - 1)) : 0;
        StartSW = 1'b1; X = 9'(x); Level = BW'(lvl);
        @(posedge Clock); #1;
        StartSW = 1'b0; X = 9'($urandom); Level = BW'($urandom);
        cyc = 1; stalls = 0; firstW = -1; unstable = 0; coinc = 0; endCyc = -1;
        prevStall = 1'b0; done = 1'b0; prevA = '0; prevD = '0;
        while (!done && cyc < 4 * H + 20) begin
            case (mode)
                0:       FBReady = 1'b1;
                1:       FBReady = cyc[0];
                default: FBReady = ($urandom_range(0, 9) < 7);
            endcase
            if (cyc == injectAt) begin
                StartSW = 1'b1; X = 9'(x ^ 'h1ff); Level = BW'(lvl + 37);
            end
            @(negedge Clock);
            if (cyc == 1) chk({tag, "_busy1"}, BusySW, 1);
            if (abortAt >= 0 && FBWriteEn && qa.size() == abortAt) begin
                Reset = 1'b1; #1;
                chk({tag, "_rst_outputs"}, {BusySW, EndSW, FBWriteEn, FBAddr, FBData}, 0);
                StartSW = 1'b0;
                repeat (2) begin
                    @(negedge Clock);
                    if (EndSW) coinc++;
                end
                chk({tag, "_rst_no_end"}, coinc, 0);
                Reset = 1'b0;
                foreach (pk[i]) pk[i] = 0;
                return;
            end
            if (FBWriteEn) begin
                if (firstW < 0) firstW = cyc;
                if (FBReady) begin qa.push_back(int'(FBAddr)); qd.push_back(int'(FBData)); end
                else stalls++;
            end
            if (prevStall && (!FBWriteEn || FBAddr !== prevA || FBData !== prevD)) unstable++;
            prevStall = FBWriteEn && !FBReady;
            prevA = FBAddr; prevD = FBData;
            if (EndSW) begin
                done = 1'b1; endCyc = cyc;
                if (FBWriteEn || BusySW) coinc++;
            end
            if (!done) begin @(posedge Clock); #1; StartSW = 1'b0; cyc++; end
        end
        FBReady = 1'b1;
        chk({tag, "_end_seen"}, done, 1);
        chk({tag, "_first_wr_cycle"}, firstW, 1 + PK);
        chk({tag, "_num_writes"}, qa.size(), H);
        chk({tag, "_end_cycle"}, endCyc, H + 1 + PK + stalls);
        chk({tag, "_stall_stable"}, unstable, 0);
        chk({tag, "_end_vs_busy_wr"}, coinc, 0);
        bad = 0;
        foreach (qa[i]) begin
            if (qa[i] != ((((H - 1 - i) & 255) << 9) | x) || qd[i] != expCode(i, lc, p)) bad++;
        end
        chk({tag, "_rows"}, bad, 0);
        if (PEAK) pk[x] = p;
    endtask

    initial begin
        foreach (pk[i]) pk[i] = 0;
        Reset = 1'b1; StartSW = 1'b0; FBReady = 1'b1; X = '0; Level = '0;
        #1;
        chk("reset_outputs", {BusySW, EndSW, FBWriteEn, FBAddr, FBData}, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        waitIdle("init");

        runCol(5, 3, 0, -1, -1, "basic");
        idle(2);
        runCol(9, 300, 0, -1, -1, "clamp");
        idle(2);
        runCol(10, 0, 0, -1, -1, "zero");
        idle(2);
        runCol(11, 120, 1, -1, -1, "toggle");
        idle(2);
        runCol(12, 77, 0, 50, -1, "inject");
        idle(2);
        runCol(13, 20, 2, -1, -1, "b2b_a");
        runCol(14, 200, 0, -1, -1, "b2b_b");
        idle(2);
        runCol(15, 60, 0, -1, 100, "abort");
        waitIdle("abort");
        runCol(16, 90, 0, -1, -1, "after_rst");
        idle(1);
        runCol(7, 50, 0, -1, -1, "peak1");
        idle(1);
        runCol(7, 10, 0, -1, -1, "peak2");
        for (int k = 0; k < 6; k++) begin
            idle($urandom_range(0, 3));
            runCol($urandom_range(0, 511), $urandom_range(0, 511), 2, -1, -1, "rand");
        end
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
